// File: rtl/acc_control_fsm.sv
// Control unit for the 8-bit accumulator machine.
// Fetches an instruction, decodes its opcode and sequences the datapath
// (A-register, PC, IR, memory) through one execute step per instruction.
// All control outputs are registered from the next state. The two
// conditional-jump outputs are the only exception: they combine a
// registered "in JZ/JPOS" qualifier with the live accumulator flags, so
// the flags are sampled in the jump state itself.
//
// Handshake: Enter is a level-sensitive user strobe. INPUT waits for
// Enter=1, A is loaded for exactly one cycle (INLD), and INREL then waits
// for Enter=0. A held press therefore loads A only once, and the next
// fetch starts only after the key is released.
module acc_control_fsm #(
  parameter int OP_W   = 3,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [OP_W+ADDR_W-1:0]   IR,
  input  logic                     Aeq0,
  input  logic                     Apos,
  input  logic                     Enter,
  output logic                     IRload,
  output logic                     PCload,
  output logic                     JMPmux,
  output logic                     Meminst,
  output logic                     MemWr,
  output logic [1:0]               Asel,
  output logic                     Aload,
  output logic                     Sub,
  output logic                     Halt,
  output logic [3:0]               state
);

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd3,
    S_STORE  = 4'd4,
    S_ADD    = 4'd5,
    S_SUB    = 4'd6,
    S_INPUT  = 4'd7,
    S_INLD   = 4'd8,
    S_INREL  = 4'd9,
    S_JZ     = 4'd10,
    S_JPOS   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_INPUT = OP_W'(4);
  localparam logic [OP_W-1:0] OP_JZ    = OP_W'(5);
  localparam logic [OP_W-1:0] OP_JPOS  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(7);

  localparam logic [1:0] ASEL_ALU   = 2'b00;
  localparam logic [1:0] ASEL_INPUT = 2'b01;
  localparam logic [1:0] ASEL_MEM   = 2'b10;

  // Registered control word; also serves as a debug view of the decoded outputs.
  typedef struct packed {
    logic       irload;
    logic       pcload;
    logic       meminst;
    logic       memwr;
    logic [1:0] asel;
    logic       aload;
    logic       sub;
    logic       halt;
    logic       jz;
    logic       jpos;
  } ctl_t;

  // Kept as a plain vector so the unused codes 13-15 are representable and recoverable.
  logic [3:0]      state_q;
  logic [3:0]      state_d;
  ctl_t            ctl_q;
  ctl_t            ctl_d;
  logic [OP_W-1:0] opcode;

  assign opcode = IR[OP_W+ADDR_W-1:ADDR_W];

  // The address field goes straight to the datapath; the control unit only decodes the opcode.
  logic unused_addr;
  assign unused_addr = ^IR[ADDR_W-1:0];

  // Next-state selection.
  always_comb begin
    state_d = S_START;
    case (state_q)
      S_START:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD:  state_d = S_LOAD;
          OP_STORE: state_d = S_STORE;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_INPUT: state_d = S_INPUT;
          OP_JZ:    state_d = S_JZ;
          OP_JPOS:  state_d = S_JPOS;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_START;
        endcase
      end
      S_LOAD:   state_d = S_FETCH;
      S_STORE:  state_d = S_FETCH;
      S_ADD:    state_d = S_FETCH;
      S_SUB:    state_d = S_FETCH;
      S_INPUT:  state_d = Enter ? S_INLD : S_INPUT;
      S_INLD:   state_d = S_INREL;
      S_INREL:  state_d = Enter ? S_INREL : S_FETCH;
      S_JZ:     state_d = S_FETCH;
      S_JPOS:   state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_START;
    endcase
  end

  // Control word for the state being entered, so outputs appear registered with the state.
  always_comb begin
    ctl_d = '0;
    ctl_d.asel = ASEL_ALU;
    case (state_d)
      S_FETCH: begin
        ctl_d.meminst = 1'b1;
        ctl_d.irload  = 1'b1;
        ctl_d.pcload  = 1'b1;
      end
      S_LOAD: begin
        ctl_d.asel  = ASEL_MEM;
        ctl_d.aload = 1'b1;
      end
      S_STORE: ctl_d.memwr = 1'b1;
      S_ADD: begin
        ctl_d.asel  = ASEL_ALU;
        ctl_d.aload = 1'b1;
      end
      S_SUB: begin
        ctl_d.asel  = ASEL_ALU;
        ctl_d.sub   = 1'b1;
        ctl_d.aload = 1'b1;
      end
      S_INLD: begin
        ctl_d.asel  = ASEL_INPUT;
        ctl_d.aload = 1'b1;
      end
      S_JZ:    ctl_d.jz   = 1'b1;
      S_JPOS:  ctl_d.jpos = 1'b1;
      S_HALT:  ctl_d.halt = 1'b1;
      default: ctl_d = '0;
    endcase
  end

  // State and control-word registers; synchronous reset overrides every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_START;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
    end
  end

  // Jump outputs: the registered jump-state qualifier gated by the live flag.
  logic take_jump;
  assign take_jump = (ctl_q.jz & Aeq0) | (ctl_q.jpos & Apos);

  assign IRload  = ctl_q.irload;
  assign PCload  = ctl_q.pcload | take_jump;
  assign JMPmux  = take_jump;
  assign Meminst = ctl_q.meminst;
  assign MemWr   = ctl_q.memwr;
  assign Asel    = ctl_q.asel;
  assign Aload   = ctl_q.aload;
  assign Sub     = ctl_q.sub;
  assign Halt    = ctl_q.halt;
  assign state   = state_q;

  // Structural invariants of the control word.
  a_load_xor_write: assert property (@(posedge clk) disable iff (reset) !(Aload && MemWr));
  a_asel_legal:     assert property (@(posedge clk) disable iff (reset) Asel != 2'b11);
  a_irload_fetch:   assert property (@(posedge clk) disable iff (reset) IRload |-> (state_q == S_FETCH));

endmodule

// File: tb/tb_acc_control_fsm.sv
// Bench for acc_control_fsm: instruction-level reference model feeding an
// expected-response queue, with an independent monitor comparing every cycle.
module tb_acc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] IR;
  logic       Aeq0, Apos, Enter;
  logic       IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Halt;
  logic [1:0] Asel;
  logic [3:0] state;

  acc_control_fsm dut (
    .clk(clk), .reset(reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
    .IRload(IRload), .PCload(PCload), .JMPmux(JMPmux), .Meminst(Meminst),
    .MemWr(MemWr), .Asel(Asel), .Aload(Aload), .Sub(Sub), .Halt(Halt), .state(state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  localparam int ST_START = 0, ST_FETCH = 1, ST_DECODE = 2, ST_LOAD = 3, ST_STORE = 4;
  localparam int ST_ADD = 5, ST_SUB = 6, ST_INPUT = 7, ST_INLD = 8, ST_INREL = 9;
  localparam int ST_JZ = 10, ST_JPOS = 11, ST_HALT = 12;

  localparam logic [2:0] OP_LOAD = 3'd0, OP_STORE = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3;
  localparam logic [2:0] OP_INPUT = 3'd4, OP_JZ = 3'd5, OP_JPOS = 3'd6, OP_HALT = 3'd7;

  // ---------------- scoreboard ----------------
  logic [13:0] exp_q[$];
  string       tag_q[$];
  int          total = 0;
  int          bad   = 0;

  // Expected {state, IRload, PCload, JMPmux, Meminst, MemWr, Asel, Aload, Sub, Halt}
  // for a cycle spent in state st, with the accumulator flags seen in that cycle.
  function automatic logic [13:0] ref_out(input int st, input logic z, input logic p);
    logic irl, pcl, jmp, mi, mw, al, sb, hl;
    logic [1:0] as;
    logic [3:0] s4;
    irl = 0; pcl = 0; jmp = 0; mi = 0; mw = 0; al = 0; sb = 0; hl = 0; as = 2'b00;
    s4 = st[3:0];
    case (st)
      ST_FETCH:  begin irl = 1; pcl = 1; mi = 1; end
      ST_LOAD:   begin as = 2'b10; al = 1; end
      ST_STORE:  mw = 1;
      ST_ADD:    al = 1;
      ST_SUB:    begin al = 1; sb = 1; end
      ST_INLD:   begin as = 2'b01; al = 1; end
      ST_JZ:     begin pcl = z; jmp = z; end
      ST_JPOS:   begin pcl = p; jmp = p; end
      ST_HALT:   hl = 1;
      default:   ;
    endcase
    return {s4, irl, pcl, jmp, mi, mw, as, al, sb, hl};
  endfunction

  function automatic int exec_of(input logic [2:0] op);
    case (op)
      OP_LOAD:  return ST_LOAD;
      OP_STORE: return ST_STORE;
      OP_ADD:   return ST_ADD;
      OP_SUB:   return ST_SUB;
      OP_INPUT: return ST_INPUT;
      OP_JZ:    return ST_JZ;
      OP_JPOS:  return ST_JPOS;
      default:  return ST_HALT;
    endcase
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  // ---------------- driver ----------------
  // One clock period in state st: record the expected view, drive this cycle's inputs.
  task automatic win(input int st, input string tag, input logic rst, input logic [7:0] ir,
                     input logic z, input logic p, input logic ent);
    reset = rst; IR = ir; Aeq0 = z; Apos = p; Enter = ent;
    exp_q.push_back(ref_out(st, z, p));
    tag_q.push_back(tag);
    @(posedge clk); #1;
  endtask

  // One whole instruction, starting in FETCH. rst_last asserts reset in its final cycle.
  task automatic instr(input logic [2:0] op, input logic [4:0] addr, input logic z, input logic p,
                       input int wait_n, input int hold_n, input int halt_n,
                       input logic rst_last, input string tag);
    logic [7:0] ir;
    ir = {op, addr};
    win(ST_FETCH, tag, 1'b0, ir, rb(), rb(), 1'b0);
    win(ST_DECODE, tag, 1'b0, ir, rb(), rb(), 1'b0);
    if (op == OP_INPUT) begin
      for (int i = 0; i < wait_n; i++) win(ST_INPUT, tag, 1'b0, ir, rb(), rb(), 1'b0);
      win(ST_INPUT, tag, 1'b0, ir, rb(), rb(), 1'b1);
      win(ST_INLD, tag, 1'b0, ir, rb(), rb(), 1'b1);
      for (int i = 0; i < hold_n; i++) win(ST_INREL, tag, 1'b0, ir, rb(), rb(), 1'b1);
      win(ST_INREL, tag, rst_last, ir, rb(), rb(), rst_last);
    end else if (op == OP_HALT) begin
      for (int i = 0; i < halt_n - 1; i++) win(ST_HALT, tag, 1'b0, ir, rb(), rb(), rb());
      win(ST_HALT, tag, rst_last, ir, rb(), rb(), rb());
    end else begin
      win(exec_of(op), tag, rst_last, ir, z, p, 1'b0);
    end
    if (rst_last) win(ST_START, "after_reset", 1'b0, ir, rb(), rb(), 1'b0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [13:0] got, e;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        got = {state, IRload, PCload, JMPmux, Meminst, MemWr, Asel, Aload, Sub, Halt};
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL %s: state=%0d ctl=%b, expected state=%0d ctl=%b",
                   t, got[13:10], got[9:0], e[13:10], e[9:0]);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] op;
    reset = 1'b1; IR = 8'h00; Aeq0 = 1'b0; Apos = 1'b0; Enter = 1'b0;
    @(posedge clk); #1;
    // Reset held for a second cycle, then released: 0, 1, 2 on successive edges.
    win(ST_START, "reset_hold", 1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
    win(ST_START, "reset_release", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    instr(OP_ADD,   5'd3, 1'b0, 1'b0, 0, 0, 0, 1'b0, "add3");
    instr(OP_JZ,    5'd7, 1'b1, 1'b0, 0, 0, 0, 1'b0, "jz_taken");
    instr(OP_JZ,    5'd7, 1'b0, 1'b1, 0, 0, 0, 1'b0, "jz_not_taken");
    instr(OP_JPOS,  5'd7, 1'b0, 1'b1, 0, 0, 0, 1'b0, "jpos_taken");
    instr(OP_JPOS,  5'd7, 1'b1, 1'b0, 0, 0, 0, 1'b0, "jpos_not_taken");
    instr(OP_LOAD,  5'd9, 1'b0, 1'b0, 0, 0, 0, 1'b0, "load");
    instr(OP_STORE, 5'd1, 1'b0, 1'b0, 0, 0, 0, 1'b0, "store");
    instr(OP_SUB,   5'd2, 1'b1, 1'b1, 0, 0, 0, 1'b0, "sub");
    // Enter low 5 cycles, high 4 cycles (INPUT, INLD, INREL, INREL), then low.
    instr(OP_INPUT, 5'd0, 1'b0, 1'b0, 5, 2, 0, 1'b0, "input_press");

    // Reset during STORE and during INREL.
    instr(OP_STORE, 5'd4, 1'b0, 1'b0, 0, 0, 0, 1'b1, "store_reset");
    instr(OP_INPUT, 5'd0, 1'b0, 1'b0, 1, 1, 0, 1'b1, "inrel_reset");

    // Illegal state 13 injected while waiting in INPUT.
    win(ST_FETCH, "illegal", 1'b0, {OP_INPUT, 5'd0}, 1'b0, 1'b0, 1'b0);
    win(ST_DECODE, "illegal", 1'b0, {OP_INPUT, 5'd0}, 1'b0, 1'b0, 1'b0);
    win(ST_INPUT, "illegal", 1'b0, {OP_INPUT, 5'd0}, 1'b0, 1'b0, 1'b0);
    force dut.state_q = 4'd13;
    #1;
    release dut.state_q;
    reset = 1'b0; Enter = 1'b0; Aeq0 = 1'b0; Apos = 1'b0;
    exp_q.push_back(ref_out(13, 1'b0, 1'b0));
    tag_q.push_back("illegal_13");
    @(posedge clk); #1;
    win(ST_START, "illegal_recover", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Randomized instruction stream (HALT kept for the end).
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 6));
      instr(op, 5'($urandom_range(0, 31)), rb(), rb(),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0,
            ($urandom_range(0, 15) == 0), "random");
    end

    // HALT held 20 cycles, released only by reset, then normal operation resumes.
    instr(OP_HALT, 5'd0, 1'b0, 1'b0, 0, 0, 20, 1'b1, "halt");
    instr(OP_ADD, 5'd1, 1'b0, 1'b0, 0, 0, 0, 1'b0, "post_halt_add");

    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected cycles left unchecked, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
